operand_fetch: RTL and testbench
================================

// Module: operand_fetch
// PURPOSE
//  Decode/operand-fetch stage on the read side of the MIPS register file. Takes one
//  fetched instruction, drives rs/rt read addresses, captures operands into an output
//  pipeline register. Tracks in-flight destinations in a busy scoreboard and stalls
//  RAW/WAW hazards until writeback clears them. Sits between fetch and execute.
// PARAMETERS
//  DATA_W   32  operand/instruction/pc width
//  NREG     32  architectural registers (address width 5)
// PORTS
//  clk          in   1   clock, all state on posedge
//  rstd         in   1   asynchronous active-low reset
//  in_valid     in   1   fetch presents instruction
//  in_ready     out  1   stage accepts instruction this cycle
//  in_instr     in   32  instruction word
//  in_pc        in   32  pc of instruction
//  rf_raddr1    out  5   register file read address 1 (= in_instr[25:21])
//  rf_raddr2    out  5   register file read address 2 (= in_instr[20:16])
//  rf_rdata1    in   32  register file read data 1 (combinational)
//  rf_rdata2    in   32  register file read data 2 (combinational)
//  wb_we        in   1   writeback write enable (same as register file write port)
//  wb_addr      in   5   writeback register address
//  wb_data      in   32  writeback data
//  out_valid    out  1   decoded instruction valid to execute
//  out_ready    in   1   execute accepts
//  out_op       out  6   opcode [31:26]
//  out_funct    out  6   funct [5:0]
//  out_dst      out  5   destination register (0 = no write)
//  out_rs_val   out  32  rs operand
//  out_rt_val   out  32  rt operand
//  out_imm      out  32  sign-extended [15:0]
//  out_pc       out  32  pc of instruction
// BEHAVIOUR
//  - Reset (rstd=0, async): out_valid=0, all out_* data=0, busy[31:0]=0. in_ready
//    combinational, 0 while in reset. Reset mid-stall drops held instruction.
//  - rf_raddr1/2 driven combinationally from in_instr every cycle.
//  - Dest decode: op=0 -> [15:11]; op in {08,09,0A,0B,0C,0D,0E,0F,23} -> [20:16];
//    else none. Dest 0 treated as none. Uses rt: op in {00,04,05,2B}; rs always.
//  - Hazard = in_valid & (busy[rs] | (uses_rt & busy[rt]) | (dst!=0 & busy[dst])),
//    register 0 never busy. in_ready = ~hazard & (~out_valid | out_ready).
//  - Accept (in_valid & in_ready): out_* loaded next posedge, out_valid=1; latency 1.
//    Else if out_ready: out_valid<=0. Else out_* held stable (no change while stalled).
//  - Operand of register 0 forced to 0 regardless of rf_rdata.
//  - Scoreboard: accept with dst!=0 sets busy[dst]; wb_we & wb_addr!=0 clears
//    busy[wb_addr]. Same register set and cleared in one cycle -> set wins.
//  - WAW stall guarantees at most one outstanding write per register.
//  - wb_we with non-busy address: register file written, busy unchanged.
// CONFIGURATION
//  OPERAND_BYPASS_EN defined: a source whose busy bit is cleared by wb_we this cycle
//  is not a hazard; operand taken from wb_data instead of rf_rdata (same-cycle
//  bypass). Undefined: such source stalls one extra cycle, reads register file next
//  cycle. WAW check never bypassed in either build.
// TESTING
//  - Reset: rstd=0 mid-stream -> out_valid=0, busy=0, in_ready=1 after release.
//  - addu $3,$1,$2 with rf r1=5,r2=7 -> next cycle out_valid=1, rs=5, rt=7, dst=3, busy[3]=1.
//  - addi $4,$3,1 right after -> in_ready=0 until wb_we addr 3; bypass build accepts that
//    cycle with rs=wb_data, non-bypass accepts one cycle later.
//  - out_ready=0 for 3 cycles -> out_* stable, in_ready=0, busy unchanged.
//  - Instr reading $0 with rf_rdata1=FFFFFFFF -> out_rs_val=0; addi $0 -> dst=0, no busy.
//  - lw $5 issue and wb_we addr 5 same cycle as new lw $5 accept -> busy[5] stays 1.

Source files
------------

// File: rtl/operand_fetch.sv
// operand_fetch: decode / operand-fetch stage between fetch and execute.
// Drives register file read addresses from the incoming instruction. Captures
// decoded fields and operands into a one-deep output register. A busy
// scoreboard of in-flight destinations stalls RAW and WAW hazards until
// writeback clears them.
// Optional feature macro: OPERAND_BYPASS_EN. When it is defined, a source
// register cleared by writeback this cycle is taken from wb_data without a
// stall. The default build waits one cycle and then reads the register file.
module operand_fetch #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  localparam int AW    = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rstd,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_instr,
  input  logic [DATA_W-1:0] in_pc,
  output logic [AW-1:0]     rf_raddr1,
  output logic [AW-1:0]     rf_raddr2,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2,
  input  logic              wb_we,
  input  logic [AW-1:0]     wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [5:0]        out_op,
  output logic [5:0]        out_funct,
  output logic [AW-1:0]     out_dst,
  output logic [DATA_W-1:0] out_rs_val,
  output logic [DATA_W-1:0] out_rt_val,
  output logic [DATA_W-1:0] out_imm,
  output logic [DATA_W-1:0] out_pc
);

  typedef struct packed {
    logic [5:0]        op;
    logic [5:0]        funct;
    logic [AW-1:0]     dst;
    logic [DATA_W-1:0] rsVal;
    logic [DATA_W-1:0] rtVal;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc;
  } stageT;

  logic [5:0]      op;
  logic [AW-1:0]   rs, rt, rd, dst;
  logic            usesRt;
  logic [NREG-1:0] busy, setMask, clrMask;
  logic            wbClr, rsFwd, rtFwd, rsBusy, rtBusy, hazard, accept;
  stageT           nxt, outQ;

  assign op        = in_instr[31:26];
  assign rs        = in_instr[25:21];
  assign rt        = in_instr[20:16];
  assign rd        = in_instr[15:11];
  assign rf_raddr1 = rs;
  assign rf_raddr2 = rt;

  // Destination and rt-usage decode; rd/rt of 0 naturally decodes to "no write"
  always_comb begin
    dst = '0;
    case (op)
      6'h00:                      dst = rd;
      6'h08, 6'h09, 6'h0A, 6'h0B,
      6'h0C, 6'h0D, 6'h0E, 6'h0F,
      6'h23:                      dst = rt;
      default:                    dst = '0;
    endcase
    usesRt = (op == 6'h00) || (op == 6'h04) || (op == 6'h05) || (op == 6'h2B);
  end

  // Register 0 is never tracked, so a write to it never clears anything
  assign wbClr = wb_we && (wb_addr != '0);

`ifdef OPERAND_BYPASS_EN
  // Source being retired this cycle: forward wb_data instead of stalling
  assign rsFwd = wbClr && (wb_addr == rs) && busy[rs];
  assign rtFwd = wbClr && (wb_addr == rt) && busy[rt];
`else
  assign rsFwd = 1'b0;
  assign rtFwd = 1'b0;
`endif

  assign rsBusy = busy[rs] & ~rsFwd;
  assign rtBusy = busy[rt] & ~rtFwd;
  // WAW uses the raw busy bit so a register never has two writes outstanding
  assign hazard = in_valid & (rsBusy | (usesRt & rtBusy) | ((dst != '0) & busy[dst]));
  assign in_ready = rstd & ~hazard & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;

  // Next output-register contents; register 0 reads as zero whatever the file says
  always_comb begin
    nxt       = '0;
    nxt.op    = op;
    nxt.funct = in_instr[5:0];
    nxt.dst   = dst;
    nxt.rsVal = (rs == '0) ? '0 : (rsFwd ? wb_data : rf_rdata1);
    nxt.rtVal = (rt == '0) ? '0 : (rtFwd ? wb_data : rf_rdata2);
    nxt.imm   = {{(DATA_W-16){in_instr[15]}}, in_instr[15:0]};
    nxt.pc    = in_pc;
  end

  // Scoreboard set/clear masks for this cycle
  always_comb begin
    setMask = '0;
    clrMask = '0;
    if (accept && (dst != '0)) setMask[dst] = 1'b1;
    if (wbClr)                 clrMask[wb_addr] = 1'b1;
  end

  // Busy scoreboard: set applied after clear so an issue beats a same-cycle writeback
  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) busy <= '0;
    else       busy <= (busy & ~clrMask) | setMask;
  end

  // Output pipeline register; contents frozen while execute back-pressures
  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      outQ      <= '0;
      out_valid <= 1'b0;
    end else if (accept) begin
      outQ      <= nxt;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out_op     = outQ.op;
  assign out_funct  = outQ.funct;
  assign out_dst    = outQ.dst;
  assign out_rs_val = outQ.rsVal;
  assign out_rt_val = outQ.rtVal;
  assign out_imm    = outQ.imm;
  assign out_pc     = outQ.pc;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: register file model, scoreboard of expected outputs
// pushed at acceptance and popped when execute takes the output.
module tb_operand_fetch;

  typedef struct packed {
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  dst;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] imm;
    logic [31:0] pc;
  } expT;

  logic        clk = 1'b0;
  logic        rstd;
  logic        in_valid, in_ready;
  logic [31:0] in_instr, in_pc;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid, out_ready;
  logic [5:0]  out_op, out_funct;
  logic [4:0]  out_dst;
  logic [31:0] out_rs_val, out_rt_val, out_imm, out_pc;

  logic [31:0] rf [32];
  expT         sb[$];
  expT         monAct, monExp;
  int          nChecks = 0;
  int          nFails  = 0;

  operand_fetch dut (
    .clk(clk), .rstd(rstd),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op(out_op), .out_funct(out_funct), .out_dst(out_dst),
    .out_rs_val(out_rs_val), .out_rt_val(out_rt_val),
    .out_imm(out_imm), .out_pc(out_pc)
  );

  always #5 clk = ~clk;

  // Register file: combinational read, written by the writeback port
  assign rf_rdata1 = rf[rf_raddr1];
  assign rf_rdata2 = rf[rf_raddr2];
  always @(posedge clk) if (wb_we && wb_addr != 5'd0) rf[wb_addr] <= wb_data;

  function automatic logic [31:0] rType(input logic [4:0] s, t, d, input logic [5:0] fn);
    return {6'h00, s, t, d, 5'h00, fn};
  endfunction

  function automatic logic [31:0] iType(input logic [5:0] o, input logic [4:0] s, t, input logic [15:0] im);
    return {o, s, t, im};
  endfunction

  function automatic expT mkExp(input logic [31:0] instr, input logic [4:0] d,
                                input logic [31:0] rsv, rtv, pc);
    expT e;
    e.op = instr[31:26]; e.funct = instr[5:0]; e.dst = d;
    e.rs = rsv; e.rt = rtv; e.imm = {{16{instr[15]}}, instr[15:0]}; e.pc = pc;
    return e;
  endfunction

  // Scoreboard monitor: every output handed to execute must match the oldest expectation
  always @(negedge clk) begin
    if (rstd && out_valid && out_ready) begin
      monAct = '{out_op, out_funct, out_dst, out_rs_val, out_rt_val, out_imm, out_pc};
      nChecks++;
      if (sb.size() == 0) begin
        nFails++;
        $display("FAIL sb_underflow: output pc=%h appeared with nothing expected", out_pc);
      end else begin
        monExp = sb.pop_front();
        if (monAct !== monExp) begin
          nFails++;
          $display("FAIL sb_data: got op=%h fn=%h dst=%0d rs=%h rt=%h imm=%h pc=%h want op=%h fn=%h dst=%0d rs=%h rt=%h imm=%h pc=%h",
                   monAct.op, monAct.funct, monAct.dst, monAct.rs, monAct.rt, monAct.imm, monAct.pc,
                   monExp.op, monExp.funct, monExp.dst, monExp.rs, monExp.rt, monExp.imm, monExp.pc);
        end
      end
    end
  end

  // Present an instruction until accepted or the cycle budget runs out
  task automatic issue(input logic [31:0] instr, pc, input expT e, input int maxCyc);
    bit done = 1'b0;
    in_valid = 1'b1; in_instr = instr; in_pc = pc;
    for (int n = 0; n < maxCyc && !done; n++) begin
      @(negedge clk);
      if (in_ready) begin sb.push_back(e); done = 1'b1; end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    nChecks++;
    if (!done) begin nFails++; $display("FAIL issue_timeout: pc=%h not accepted within %0d cycles", pc, maxCyc); end
  endtask

  task automatic test_reset();
    #1;
    nChecks++; if (out_valid !== 1'b0) begin nFails++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    nChecks++; if (in_ready !== 1'b0) begin nFails++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    nChecks++; if (out_pc !== 32'h0 || out_rs_val !== 32'h0) begin nFails++; $display("FAIL rst_data: pc=%h rs=%h want 0", out_pc, out_rs_val); end
    @(negedge clk); rstd = 1'b1;
    @(posedge clk); #1;
    nChecks++; if (in_ready !== 1'b1) begin nFails++; $display("FAIL rst_release_ready: got %b want 1", in_ready); end
    nChecks++; if (out_valid !== 1'b0) begin nFails++; $display("FAIL rst_release_valid: got %b want 0", out_valid); end
  endtask

  // addu $3,$1,$2 followed immediately by dependent addi $4,$3,1
  task automatic test_basic_and_raw();
    logic [31:0] i1, i2;
    i1 = rType(5'd1, 5'd2, 5'd3, 6'h21);
    i2 = iType(6'h08, 5'd3, 5'd4, 16'h0001);
    in_valid = 1'b1; in_instr = i1; in_pc = 32'h100;
    @(negedge clk);
    nChecks++; if (rf_raddr1 !== 5'd1 || rf_raddr2 !== 5'd2) begin nFails++; $display("FAIL raddr: got %0d/%0d want 1/2", rf_raddr1, rf_raddr2); end
    nChecks++; if (in_ready !== 1'b1) begin nFails++; $display("FAIL basic_ready: got %b want 1", in_ready); end
    if (in_ready) sb.push_back(mkExp(i1, 5'd3, 32'd5, 32'd7, 32'h100));
    @(posedge clk); #1;
    nChecks++; if (out_valid !== 1'b1) begin nFails++; $display("FAIL basic_latency: out_valid got %b want 1", out_valid); end
    in_instr = i2; in_pc = 32'h104;
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      nChecks++; if (in_ready !== 1'b0) begin nFails++; $display("FAIL raw_stall[%0d]: in_ready got %b want 0", n, in_ready); end
      @(posedge clk); #1;
    end
    wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'd12;
    @(negedge clk);
`ifdef OPERAND_BYPASS_EN
    nChecks++; if (in_ready !== 1'b1) begin nFails++; $display("FAIL raw_bypass: in_ready got %b want 1", in_ready); end
    if (in_ready) sb.push_back(mkExp(i2, 5'd4, 32'd12, 32'h104, 32'h104));
    @(posedge clk); #1;
    wb_we = 1'b0;
`else
    nChecks++; if (in_ready !== 1'b0) begin nFails++; $display("FAIL raw_wb_cycle: in_ready got %b want 0", in_ready); end
    @(posedge clk); #1;
    wb_we = 1'b0;
    @(negedge clk);
    nChecks++; if (in_ready !== 1'b1) begin nFails++; $display("FAIL raw_after_wb: in_ready got %b want 1", in_ready); end
    if (in_ready) sb.push_back(mkExp(i2, 5'd4, 32'd12, 32'h104, 32'h104));
    @(posedge clk); #1;
`endif
    in_valid = 1'b0;
    nChecks++; if (out_valid !== 1'b1) begin nFails++; $display("FAIL raw_out_valid: got %b want 1", out_valid); end
    @(posedge clk); #1;
  endtask

  // Execute back-pressure: output frozen, new instruction refused
  task automatic test_stall();
    logic [31:0] i1, i2;
    i1 = iType(6'h0D, 5'd1, 5'd6, 16'h00FF);
    i2 = rType(5'd1, 5'd2, 5'd7, 6'h21);
    out_ready = 1'b0;
    issue(i1, 32'h200, mkExp(i1, 5'd6, 32'd5, 32'h106, 32'h200), 2);
    in_valid = 1'b1; in_instr = i2; in_pc = 32'h204;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      nChecks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin nFails++; $display("FAIL stall_hs[%0d]: valid=%b ready=%b want 1/0", n, out_valid, in_ready); end
      nChecks++; if (out_pc !== 32'h200 || out_rs_val !== 32'd5 || out_dst !== 5'd6 || out_imm !== 32'h0FF)
        begin nFails++; $display("FAIL stall_hold[%0d]: pc=%h rs=%h dst=%0d imm=%h want 200/5/6/ff", n, out_pc, out_rs_val, out_dst, out_imm); end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    nChecks++; if (in_ready !== 1'b1) begin nFails++; $display("FAIL stall_release: in_ready got %b want 1", in_ready); end
    if (in_ready) sb.push_back(mkExp(i2, 5'd7, 32'd5, 32'd7, 32'h204));
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  // Register 0: operand forced to zero, never marked busy
  task automatic test_zero();
    logic [31:0] i1, i2, i3;
    i1 = rType(5'd0, 5'd2, 5'd8, 6'h21);
    i2 = iType(6'h08, 5'd1, 5'd0, 16'h0005);
    i3 = rType(5'd0, 5'd0, 5'd9, 6'h20);
    issue(i1, 32'h300, mkExp(i1, 5'd8, 32'd0, 32'd7, 32'h300), 2);
    issue(i2, 32'h304, mkExp(i2, 5'd0, 32'd5, 32'd0, 32'h304), 2);
    in_valid = 1'b1; in_instr = i3; in_pc = 32'h308;
    @(negedge clk);
    nChecks++; if (in_ready !== 1'b1) begin nFails++; $display("FAIL zero_not_busy: in_ready got %b want 1", in_ready); end
    if (in_ready) sb.push_back(mkExp(i3, 5'd9, 32'd0, 32'd0, 32'h308));
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  // Set beats a same-cycle clear; WAW never bypassed
  task automatic test_set_wins();
    logic [31:0] i1, i2;
    i1 = iType(6'h23, 5'd1, 5'd5, 16'hFFF0);
    i2 = iType(6'h23, 5'd1, 5'd5, 16'h0020);
    in_valid = 1'b1; in_instr = i1; in_pc = 32'h400;
    wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'h55;
    @(negedge clk);
    nChecks++; if (in_ready !== 1'b1) begin nFails++; $display("FAIL setwin_accept: in_ready got %b want 1", in_ready); end
    if (in_ready) sb.push_back(mkExp(i1, 5'd5, 32'd5, 32'h105, 32'h400));
    @(posedge clk); #1;
    wb_we = 1'b0;
    in_instr = i2; in_pc = 32'h404;
    @(negedge clk);
    nChecks++; if (in_ready !== 1'b0) begin nFails++; $display("FAIL setwin_busy: in_ready got %b want 0", in_ready); end
    @(posedge clk); #1;
    wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'h66;
    @(negedge clk);
    nChecks++; if (in_ready !== 1'b0) begin nFails++; $display("FAIL waw_no_bypass: in_ready got %b want 0", in_ready); end
    @(posedge clk); #1;
    wb_we = 1'b0;
    @(negedge clk);
    nChecks++; if (in_ready !== 1'b1) begin nFails++; $display("FAIL waw_clear: in_ready got %b want 1", in_ready); end
    if (in_ready) sb.push_back(mkExp(i2, 5'd5, 32'd5, 32'h66, 32'h404));
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  // Reset while stalled drops the held instruction and clears the scoreboard
  task automatic test_reset_mid();
    logic [31:0] i1, i2;
    i1 = rType(5'd1, 5'd2, 5'd11, 6'h21);
    i2 = iType(6'h08, 5'd11, 5'd12, 16'h0001);
    out_ready = 1'b0;
    issue(i1, 32'h500, mkExp(i1, 5'd11, 32'd5, 32'd7, 32'h500), 2);
    in_valid = 1'b1; in_instr = i2; in_pc = 32'h504;
    @(negedge clk);
    nChecks++; if (in_ready !== 1'b0) begin nFails++; $display("FAIL mid_stall: in_ready got %b want 0", in_ready); end
    #2 rstd = 1'b0;
    #1;
    nChecks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin nFails++; $display("FAIL mid_rst: valid=%b ready=%b want 0/0", out_valid, in_ready); end
    nChecks++; if (out_dst !== 5'd0 || out_rs_val !== 32'h0) begin nFails++; $display("FAIL mid_rst_data: dst=%0d rs=%h want 0/0", out_dst, out_rs_val); end
    sb.delete();
    @(negedge clk); rstd = 1'b1; out_ready = 1'b1;
    #1;
    nChecks++; if (in_ready !== 1'b1) begin nFails++; $display("FAIL mid_busy_cleared: in_ready got %b want 1", in_ready); end
    if (in_ready) sb.push_back(mkExp(i2, 5'd12, 32'h10B, 32'h10C, 32'h504));
    @(posedge clk); #1;
    in_valid = 1'b0;
    nChecks++; if (out_valid !== 1'b1) begin nFails++; $display("FAIL mid_reissue: out_valid got %b want 1", out_valid); end
    @(posedge clk); #1;
  endtask

  initial begin
    rstd = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
    wb_we = 1'b0; wb_addr = '0; wb_data = '0; out_ready = 1'b1;
    for (int i = 0; i < 32; i++) rf[i] <= 32'h100 + i;
    rf[0] <= 32'hFFFF_FFFF;
    rf[1] <= 32'd5;
    rf[2] <= 32'd7;
    test_reset();
    test_basic_and_raw();
    test_stall();
    test_zero();
    test_set_wins();
    test_reset_mid();
    nChecks++;
    if (sb.size() != 0) begin nFails++; $display("FAIL sb_leftover: %0d expected outputs never seen", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
